branch_resolve_unit: RTL

Parametrised, pipelined branch resolution unit for the RV32/RV64 integer pipeline. It takes a decoded conditional branch with its operands, PC, immediate and front-end prediction, and evaluates all six RISC-V branch conditions. It produces a taken flag, the redirect PC, a mispredict flag and a misalignment flag after a configurable number of register stages, behind valid/ready handshakes on both sides. It sits between the register-read stage and the fetch redirect logic.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_resolve_unit_cmp.sv | 34 +++
 rtl/branch_resolve_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_pkg;

  typedef enum logic [2:0] {
    F_BEQ  = 3'd0,
    F_BNE  = 3'd1,
    F_BLT  = 3'd4,
    F_BGE  = 3'd5,
    F_BLTU = 3'd6,
    F_BGEU = 3'd7
  } br_func_e;

  localparam int INSN_BYTES = 4;
  localparam int XLEN_MAX   = 64;

  // Redirect is sized for the widest XLEN; narrower builds zero-extend into it.
  typedef struct packed {
    logic                taken;
    logic                mispredict;
    logic                misaligned;
    logic                illegal;
    logic [XLEN_MAX-1:0] redirect;
  } br_res_t;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// branch_cmp: combinational evaluation of the six RISC-V branch conditions.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq, lt, ltu;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_func_e'(func))
      F_BEQ:   taken = eq;
      F_BNE:   taken = !eq;
      F_BLT:   taken = lt;
      F_BGE:   taken = !lt;
      F_BLTU:  taken = ltu;
      F_BGEU:  taken = !ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution (1 or 2 stages) with valid/ready on both sides.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_func,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_misaligned,
  output logic            out_illegal,
`ifdef BRANCH_STATS_EN
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count,
`endif
  output logic [XLEN-1:0] out_redirect
);

  logic [STAGES-1:0] vld_pipe;
  logic              adv_out, adv0, in_fire, ld_res;

  logic [2:0]      c_func;
  logic [XLEN-1:0] c_rs1, c_rs2, c_pc, c_imm;
  logic            c_pred;

  assign adv_out   = !vld_pipe[STAGES-1] || out_ready;
  assign adv0      = (STAGES == 1) ? adv_out : (!vld_pipe[0] || adv_out);
  assign in_ready  = !vld_pipe[0] || adv0;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_pipe[STAGES-1];

  generate
    if (STAGES == 1) begin : g_s1
      always_ff @(posedge clk) begin
        if (!rst_n || flush) vld_pipe <= '0;
        else if (adv0)       vld_pipe[0] <= in_valid;
      end

      assign c_func = in_func;
      assign c_rs1  = in_rs1;
      assign c_rs2  = in_rs2;
      assign c_pc   = in_pc;
      assign c_imm  = in_imm;
      assign c_pred = in_pred_taken;
      assign ld_res = in_fire;
    end else begin : g_s2
      logic [2:0]      s0_func;
      logic [XLEN-1:0] s0_rs1, s0_rs2, s0_pc, s0_imm;
      logic            s0_pred;

      // Flush clears the valid bits only; stale operand data is harmless.
      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          vld_pipe <= '0;
        end else begin
          if (adv_out) vld_pipe[STAGES-1] <= vld_pipe[0];
          if (adv0)    vld_pipe[0]        <= in_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s0_func <= '0;
          s0_rs1  <= '0;
          s0_rs2  <= '0;
          s0_pc   <= '0;
          s0_imm  <= '0;
          s0_pred <= 1'b0;
        end else if (in_fire) begin
          s0_func <= in_func;
          s0_rs1  <= in_rs1;
          s0_rs2  <= in_rs2;
          s0_pc   <= in_pc;
          s0_imm  <= in_imm;
          s0_pred <= in_pred_taken;
        end
      end

      assign c_func = s0_func;
      assign c_rs1  = s0_rs1;
      assign c_rs2  = s0_rs2;
      assign c_pc   = s0_pc;
      assign c_imm  = s0_imm;
      assign c_pred = s0_pred;
      assign ld_res = vld_pipe[0] && adv_out;
    end
  endgenerate

  logic            cmp_taken, cmp_illegal;
  logic [XLEN-1:0] target, fallthru;
  br_res_t         res_d, res_q;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .func    (c_func),
    .rs1     (c_rs1),
    .rs2     (c_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign target   = c_pc + c_imm;
  assign fallthru = c_pc + XLEN'(INSN_BYTES);

  always_comb begin
    res_d            = '0;
    res_d.taken      = cmp_taken;
    res_d.illegal    = cmp_illegal;
    res_d.mispredict = cmp_taken ^ c_pred;
    res_d.misaligned = cmp_taken & target[1];
    res_d.redirect   = XLEN_MAX'(cmp_taken ? target : fallthru);
  end

  // Result register only loads on a forward move, so it holds under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n)      res_q <= '0;
    else if (ld_res) res_q <= res_d;
  end

  assign out_taken      = res_q.taken;
  assign out_mispredict = res_q.mispredict;
  assign out_misaligned = res_q.misaligned;
  assign out_illegal    = res_q.illegal;
  assign out_redirect   = res_q.redirect[XLEN-1:0];

`ifdef BRANCH_STATS_EN
  logic out_fire;
  // An entry leaving in a flush cycle is being killed, so it is not counted.
  assign out_fire = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (out_fire) begin
      if (!out_illegal && (br_count != '1))   br_count  <= br_count + CNT_W'(1);
      if (out_mispredict && (mis_count != '1)) mis_count <= mis_count + CNT_W'(1);
    end
  end
`endif

endmodule
